// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command-frame assembler, validator and register write requester
module uart_cmd_ctrl #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 43400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_done,
    input  logic [7:0]  rx_byte,
    output logic        wr_req,
    output logic [6:0]  wr_addr,
    output logic [15:0] wr_data,
    input  logic        wr_ack,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    localparam logic [1:0] CODE_CHK     = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT = 2'd2;
    localparam logic [1:0] CODE_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_CMD = 3'd1,
        S_DH  = 3'd2,
        S_DL  = 3'd3,
        S_CHK = 3'd4,
        WREQ  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  acc_q, acc_d;
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        acc_d   = acc_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        code_d  = code_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (rx_done && rx_byte == HEADER) begin
                    state_d = S_CMD;
                end
            end

            S_CMD, S_DH, S_DL, S_CHK: begin
                // A byte arriving in the expiry cycle wins over the timeout.
                if (rx_done) begin
                    tmo_d = '0;
                    case (state_q)
                        S_CMD: begin
                            addr_d  = rx_byte[6:0];
                            acc_d   = rx_byte;
                            state_d = S_DH;
                        end
                        S_DH: begin
                            data_d[15:8] = rx_byte;
                            acc_d        = acc_q ^ rx_byte;
                            state_d      = S_DL;
                        end
                        S_DL: begin
                            data_d[7:0] = rx_byte;
                            acc_d       = acc_q ^ rx_byte;
                            state_d     = S_CHK;
                        end
                        default: begin
                            if (rx_byte == acc_q) begin
                                state_d = WREQ;
                            end else begin
                                err_d   = 1'b1;
                                code_d  = CODE_CHK;
                                state_d = IDLE;
                            end
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    err_d   = 1'b1;
                    code_d  = CODE_TIMEOUT;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            WREQ: begin
                tmo_d = '0;
                if (wr_ack) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 8'd1;
                end
                if (rx_done) begin
                    err_d  = 1'b1;
                    code_d = CODE_OVERRUN;
                end
            end

            default: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    assign wr_req    = (state_q == WREQ);
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        wr_req;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack = 1'b0;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;
    logic [7:0]  frame_cnt;

    int errors = 0;
    int checks = 0;

    uart_cmd_ctrl #(.HEADER(8'hA5), .TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_done   (rx_done),
        .rx_byte   (rx_byte),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_done = 1'b1;
        rx_byte = b;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] dh, input logic [7:0] dl, input logic [7:0] ck);
        send(8'hA5);
        send(c);
        send(dh);
        send(dl);
        send(ck);
    endtask

    task automatic ack();
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_req"},    32'(wr_req),    32'd0);
        chk({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
        chk({tag, "_wr_data"},   32'(wr_data),   32'd0);
        chk({tag, "_err"},       32'(err),       32'd0);
        chk({tag, "_err_code"},  32'(err_code),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        int seen_err;
        logic [7:0] c, dh, dl;

        // reset
        #2;
        chk_reset_vals("rst");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_reset_vals("post_rst");

        // good frame: 12^BE^EF = 43
        send(8'hA5);
        chk("hdr_busy", 32'(busy), 32'd1);
        send(8'h12);
        send(8'hBE);
        send(8'hEF);
        chk("pre_chk_req", 32'(wr_req), 32'd0);
        send(8'h43);
        chk("good_req", 32'(wr_req), 32'd1);
        chk("good_addr", 32'(wr_addr), 32'h12);
        chk("good_data", 32'(wr_data), 32'hBEEF);
        chk("good_err", 32'(err), 32'd0);
        tick();
        tick();
        chk("good_req_held", 32'(wr_req), 32'd1);
        chk("good_addr_held", 32'(wr_addr), 32'h12);
        ack();
        chk("good_req_drop", 32'(wr_req), 32'd0);
        chk("good_busy", 32'(busy), 32'd0);
        chk("good_cnt", 32'(frame_cnt), 32'd1);
        chk("good_noerr", 32'(err), 32'd0);

        // bad checksum
        frame(8'h12, 8'hBE, 8'hEF, 8'h00);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_code", 32'(err_code), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_req", 32'(wr_req), 32'd0);
        tick();
        chk("bad_err_1cyc", 32'(err), 32'd0);
        chk("bad_code_hold", 32'(err_code), 32'd1);
        chk("bad_req_never", 32'(wr_req), 32'd0);

        // timeout after CMD byte
        send(8'hA5);
        send(8'h12);
        seen_err = 0;
        for (int k = 1; k < int'(TMO); k++) begin
            tick();
            if (err) seen_err++;
        end
        chk("tmo_early", 32'(seen_err), 32'd0);
        chk("tmo_busy_before", 32'(busy), 32'd1);
        tick();
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_code", 32'(err_code), 32'd2);
        chk("tmo_busy", 32'(busy), 32'd0);
        tick();
        chk("tmo_err_1cyc", 32'(err), 32'd0);
        // 34^56^78 = 1A
        frame(8'h34, 8'h56, 8'h78, 8'h1A);
        chk("tmo_next_req", 32'(wr_req), 32'd1);
        chk("tmo_next_addr", 32'(wr_addr), 32'h34);
        chk("tmo_next_data", 32'(wr_data), 32'h5678);
        ack();
        chk("tmo_next_cnt", 32'(frame_cnt), 32'd2);

        // byte arriving in the expiry cycle is accepted
        send(8'hA5);
        for (int k = 1; k < int'(TMO); k++) tick();
        send(8'h01);
        chk("race_err", 32'(err), 32'd0);
        chk("race_busy", 32'(busy), 32'd1);
        send(8'h02);
        send(8'h03);
        send(8'h00);
        chk("race_req", 32'(wr_req), 32'd1);
        chk("race_addr", 32'(wr_addr), 32'h01);
        chk("race_data", 32'(wr_data), 32'h0203);
        ack();
        chk("race_cnt", 32'(frame_cnt), 32'd3);

        // junk then embedded header
        send(8'h00);
        chk("junk0_busy", 32'(busy), 32'd0);
        send(8'hFF);
        chk("junk1_busy", 32'(busy), 32'd0);
        chk("junk_err", 32'(err), 32'd0);
        frame(8'hA5, 8'h00, 8'h01, 8'hA4);
        chk("emb_req", 32'(wr_req), 32'd1);
        chk("emb_addr", 32'(wr_addr), 32'h25);
        chk("emb_data", 32'(wr_data), 32'h0001);

        // overrun while request pending
        send(8'h77);
        chk("ovr_err", 32'(err), 32'd1);
        chk("ovr_code", 32'(err_code), 32'd3);
        chk("ovr_req", 32'(wr_req), 32'd1);
        chk("ovr_addr", 32'(wr_addr), 32'h25);
        chk("ovr_data", 32'(wr_data), 32'h0001);
        tick();
        chk("ovr_err_1cyc", 32'(err), 32'd0);
        // overrun coincident with ack
        rx_done = 1'b1;
        rx_byte = 8'h55;
        wr_ack  = 1'b1;
        tick();
        rx_done = 1'b0;
        wr_ack  = 1'b0;
        chk("ovr_ack_err", 32'(err), 32'd1);
        chk("ovr_ack_code", 32'(err_code), 32'd3);
        chk("ovr_ack_req", 32'(wr_req), 32'd0);
        chk("ovr_ack_cnt", 32'(frame_cnt), 32'd4);

        // frame counter wrap: 251 more to 255, one more to 0
        for (int i = 0; i < 251; i++) begin
            c  = 8'(i);
            dh = 8'($urandom_range(255));
            dl = 8'($urandom_range(255));
            frame(c, dh, dl, c ^ dh ^ dl);
            ack();
        end
        chk("wrap_255", 32'(frame_cnt), 32'd255);
        frame(8'h7F, 8'hAA, 8'h55, 8'h80);
        chk("wrap_last_req", 32'(wr_req), 32'd1);
        ack();
        chk("wrap_0", 32'(frame_cnt), 32'd0);

        // asynchronous reset after DATA_H
        send(8'hA5);
        send(8'h12);
        send(8'hBE);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        tick();
        rst = 1'b0;
        tick();
        chk_reset_vals("mid_rel");
        frame(8'h12, 8'hBE, 8'hEF, 8'h43);
        chk("after_rst_req", 32'(wr_req), 32'd1);
        chk("after_rst_addr", 32'(wr_addr), 32'h12);
        chk("after_rst_data", 32'(wr_data), 32'hBEEF);
        ack();
        chk("after_rst_cnt", 32'(frame_cnt), 32'd1);
        chk("after_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
